minibyte_mem_arbiter: RTL and testbench

// - Shares the single Minibyte memory space between the CPU and a debug/programming port.
// - Arbitrates round-robin between the two requesters.
// - Decodes the address: ROM 0x00-0x1F, external RAM 0x20-0x3F, output port register at OUT_PORT_ADDR.
// - Sequences every access through a fixed wait-state window and returns a one-cycle ack per access.

---
 rtl/minibyte_mem_arbiter_if.sv | 30 +++
 rtl/minibyte_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_minibyte_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/minibyte_mem_arbiter_if.sv
// Request/response bundle between the two Minibyte requesters (CPU, debug port) and the arbiter.
// master = requester side, slave = arbiter side.
interface minibyte_mem_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;
  logic       dbg_req;
  logic       dbg_we;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic [7:0] dbg_rdata;
  logic       dbg_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack
  );
endinterface

// File: rtl/minibyte_mem_arbiter.sv
// Round-robin arbiter sharing the Minibyte memory map (ROM, RAM, output port) between CPU and debug port.
// Every access runs a fixed wait-state window and returns a single-cycle ack.
//
//   state    | meaning
//   S_IDLE   | waiting for a request; grants and latches the winner's command
//   S_ACCESS | WAIT_STATES+1 cycles driving the latched address; region action on the last one
//   S_RESP   | one-cycle ack to the owner
module minibyte_mem_arbiter #(
  parameter int unsigned WAIT_STATES   = 1,
  parameter logic [7:0]  OUT_PORT_ADDR = 8'h40
) (
  input  logic                          clk,
  input  logic                          rst,
  minibyte_mem_arbiter_if.slave         req_if,
  output logic [4:0]                    rom_addr_o,
  input  logic [7:0]                    rom_data_i,
  output logic [4:0]                    ram_addr_o,
  output logic                          ram_we_o,
  output logic [7:0]                    ram_wdata_o,
  input  logic [7:0]                    ram_rdata_i,
  output logic [7:0]                    out_port_o,
  output logic                          busy_o,
  output logic                          owner_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] dbg_rdata_q, dbg_rdata_d;
  logic [7:0] out_port_q, out_port_d;

  logic       grant_dbg;
  logic       final_cycle;
  logic       hit_out, hit_rom, hit_ram;
  logic [7:0] rd_val;

  // Output port decode wins so a relocated OUT_PORT_ADDR can shadow ROM/RAM.
  always_comb begin
    hit_out = (addr_q == OUT_PORT_ADDR);
    hit_rom = !hit_out && (addr_q < 8'h20);
    hit_ram = !hit_out && (addr_q[7:5] == 3'b001);
    rd_val  = 8'h00;
    if (hit_out)      rd_val = out_port_q;
    else if (hit_rom) rd_val = rom_data_i;
    else if (hit_ram) rd_val = ram_rdata_i;
  end

  assign grant_dbg   = (req_if.cpu_req && req_if.dbg_req) ? ~last_owner_q : req_if.dbg_req;
  assign final_cycle = (state_q == S_ACCESS) && (cnt_q == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      cnt_q        <= 3'd0;
      cpu_rdata_q  <= 8'h00;
      dbg_rdata_q  <= 8'h00;
      out_port_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      out_port_q   <= out_port_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    out_port_d   = out_port_q;
    case (state_q)
      S_IDLE: begin
        if (req_if.cpu_req || req_if.dbg_req) begin
          owner_d = grant_dbg;
          we_d    = grant_dbg ? req_if.dbg_we    : req_if.cpu_we;
          addr_d  = grant_dbg ? req_if.dbg_addr  : req_if.cpu_addr;
          wdata_d = grant_dbg ? req_if.dbg_wdata : req_if.cpu_wdata;
          cnt_d   = WAIT_CNT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 3'd0) begin
          if (!we_q) begin
            if (owner_q) dbg_rdata_d = rd_val;
            else         cpu_rdata_d = rd_val;
          end else if (hit_out) begin
            out_port_d = wdata_q;
          end
          last_owner_d = owner_q;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_if.cpu_ack   = (state_q == S_RESP) && !owner_q;
  assign req_if.dbg_ack   = (state_q == S_RESP) &&  owner_q;
  assign req_if.cpu_rdata = cpu_rdata_q;
  assign req_if.dbg_rdata = dbg_rdata_q;

  assign rom_addr_o  = addr_q[4:0];
  assign ram_addr_o  = addr_q[4:0];
  assign ram_wdata_o = wdata_q;
  assign ram_we_o    = final_cycle && we_q && hit_ram;
  assign out_port_o  = out_port_q;
  assign busy_o      = (state_q != S_IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_minibyte_mem_arbiter.sv
// Directed bench for minibyte_mem_arbiter: vector table of single accesses plus
// hand sequences for async reset, dropped request, reset mid-access and round-robin.
module tb_minibyte_mem_arbiter;
  localparam int WS = 1;

  logic       clk;
  logic       rst;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic [4:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [7:0] out_port;
  logic       busy;
  logic       owner;
  logic [7:0] ram_mem [32];

  minibyte_mem_arbiter_if bus();

  minibyte_mem_arbiter #(.WAIT_STATES(WS), .OUT_PORT_ADDR(8'h40)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (bus),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .out_port_o  (out_port),
    .busy_o      (busy),
    .owner_o     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model returns its own address; RAM model is a 32-byte synchronous-write array.
  assign rom_data  = {3'b000, rom_addr};
  assign ram_rdata = ram_mem[ram_addr];
  always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_wdata;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cpu_ack_tot = 0;
  int         dbg_ack_tot = 0;
  int         we_tot = 0;
  logic [4:0] cap_addr = 5'd0;
  logic [7:0] cap_data = 8'd0;

  always @(negedge clk) begin
    if (bus.cpu_ack) cpu_ack_tot++;
    if (bus.dbg_ack) dbg_ack_tot++;
    if (ram_we) begin
      we_tot++;
      cap_addr = ram_addr;
      cap_data = ram_wdata;
    end
  end

  typedef struct {
    logic       who;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic [7:0] exp_out;
    int         exp_we;
    logic [4:0] exp_waddr;
    logic [7:0] exp_wdat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic who, input logic val);
    if (who) bus.dbg_req = val;
    else     bus.cpu_req = val;
  endtask

  task automatic drive(input logic who, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    if (who) begin
      bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata; bus.dbg_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    end
  endtask

  task automatic do_access(input vec_t v, input bit drop_early, input string tag);
    int cyc;
    bit got;
    int c0, d0, w0;
    c0 = cpu_ack_tot; d0 = dbg_ack_tot; w0 = we_tot;
    drive(v.who, v.we, v.addr, v.wdata);
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk($sformatf("%s busy", tag), busy, 1);
        if (drop_early) set_req(v.who, 1'b0);
      end
      if (v.who ? bus.dbg_ack : bus.cpu_ack) begin
        got = 1;
        set_req(v.who, 1'b0);
        chk($sformatf("%s latency", tag), cyc, WS + 2);
        chk($sformatf("%s rdata", tag), v.who ? bus.dbg_rdata : bus.cpu_rdata, v.exp_rdata);
        chk($sformatf("%s out_port", tag), out_port, v.exp_out);
        chk($sformatf("%s owner", tag), owner, v.who);
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s ack timeout: got no ack, expected ack by cycle %0d", tag, WS + 2);
      set_req(v.who, 1'b0);
    end
    @(negedge clk);
    #1;
    chk($sformatf("%s own ack count", tag), v.who ? dbg_ack_tot - d0 : cpu_ack_tot - c0, 1);
    chk($sformatf("%s other ack count", tag), v.who ? cpu_ack_tot - c0 : dbg_ack_tot - d0, 0);
    chk($sformatf("%s ram_we count", tag), we_tot - w0, v.exp_we);
    if (v.exp_we != 0) begin
      chk($sformatf("%s ram_addr", tag), cap_addr, v.exp_waddr);
      chk($sformatf("%s ram_wdata", tag), cap_data, v.exp_wdat);
    end
  endtask

  initial begin
    int   c0, d0, w0;
    int   seq[4];
    int   n, cyc, first_lat;
    vec_t v;

    //        who   we    addr   wdata  rdata  out    we  waddr  wdat
    vecs[0]  = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 0, 5'd0,  8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h40, 8'h7F, 8'h01, 8'h7F, 0, 5'd0,  8'h00};
    vecs[2]  = '{1'b1, 1'b1, 8'h25, 8'hA5, 8'h00, 8'h7F, 1, 5'd5,  8'hA5};
    vecs[3]  = '{1'b0, 1'b0, 8'h25, 8'h00, 8'hA5, 8'h7F, 0, 5'd0,  8'h00};
    vecs[4]  = '{1'b0, 1'b1, 8'h03, 8'h11, 8'hA5, 8'h7F, 0, 5'd0,  8'h00};
    vecs[5]  = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h7F, 0, 5'd0,  8'h00};
    vecs[6]  = '{1'b1, 1'b0, 8'h40, 8'h00, 8'h7F, 8'h7F, 0, 5'd0,  8'h00};
    vecs[7]  = '{1'b1, 1'b0, 8'h1F, 8'h00, 8'h1F, 8'h7F, 0, 5'd0,  8'h00};
    vecs[8]  = '{1'b0, 1'b1, 8'h3F, 8'h5A, 8'h00, 8'h7F, 1, 5'd31, 8'h5A};
    vecs[9]  = '{1'b1, 1'b0, 8'h3F, 8'h00, 8'h5A, 8'h7F, 0, 5'd0,  8'h00};
    vecs[10] = '{1'b0, 1'b1, 8'h40, 8'hC3, 8'h00, 8'hC3, 0, 5'd0,  8'h00};
    vecs[11] = '{1'b1, 1'b0, 8'h40, 8'h00, 8'hC3, 8'hC3, 0, 5'd0,  8'h00};

    rst = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h00; bus.dbg_wdata = 8'h00;

    // Async reset asserted before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst cpu_ack", bus.cpu_ack, 0);
    chk("rst dbg_ack", bus.dbg_ack, 0);
    chk("rst cpu_rdata", bus.cpu_rdata, 0);
    chk("rst dbg_rdata", bus.dbg_rdata, 0);
    chk("rst out_port", out_port, 0);
    chk("rst ram_we", ram_we, 0);
    chk("rst busy", busy, 0);
    chk("rst owner", owner, 0);
    chk("rst rom_addr", rom_addr, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_wdata", ram_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) do_access(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Request withdrawn during ACCESS still completes.
    v = '{1'b0, 1'b0, 8'h1E, 8'h00, 8'h1E, 8'hC3, 0, 5'd0, 8'h00};
    do_access(v, 1'b1, "drop");

    // Reset in the middle of a write to the output port.
    c0 = cpu_ack_tot; d0 = dbg_ack_tot; w0 = we_tot;
    drive(1'b0, 1'b1, 8'h40, 8'h99);
    @(negedge clk);
    chk("midrst busy before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_port", out_port, 0);
    chk("midrst busy", busy, 0);
    chk("midrst cpu_ack", bus.cpu_ack, 0);
    chk("midrst cpu_rdata", bus.cpu_rdata, 0);
    chk("midrst dbg_rdata", bus.dbg_rdata, 0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst ack count", (cpu_ack_tot - c0) + (dbg_ack_tot - d0), 0);
    chk("midrst ram_we count", we_tot - w0, 0);
    chk("midrst out_port after", out_port, 0);

    // Simultaneous requests held continuously: CPU first, then strict alternation.
    c0 = cpu_ack_tot; d0 = dbg_ack_tot;
    for (int i = 0; i < 4; i++) seq[i] = 2;
    drive(1'b0, 1'b0, 8'h02, 8'h00);
    drive(1'b1, 1'b0, 8'h03, 8'h00);
    n = 0; cyc = 0; first_lat = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_ack) begin
        seq[n] = 0;
        n++;
        if (n == 1) first_lat = cyc;
      end else if (bus.dbg_ack) begin
        seq[n] = 1;
        n++;
      end
      if (n == 4) begin
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
      end
    end
    if (n < 4) begin
      n_cmp++;
      n_err++;
      $display("FAIL rr timeout: got %0d acks, expected 4", n);
      bus.cpu_req = 1'b0;
      bus.dbg_req = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("rr first latency", first_lat, WS + 2);
    for (int i = 0; i < 4; i++) chk($sformatf("rr grant%0d", i), seq[i], i % 2);
    chk("rr cpu_rdata", bus.cpu_rdata, 8'h02);
    chk("rr dbg_rdata", bus.dbg_rdata, 8'h03);
    chk("rr cpu acks", cpu_ack_tot - c0, 2);
    chk("rr dbg acks", dbg_ack_tot - d0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
